// File: rtl/seg7_to_bcd_scanner.sv
// Samples a multiplexed active-high 7-segment bus and recovers per-digit
// BCD once a {an, seg} pattern has been stable for STABLE_CYCLES samples.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   seg[6:0]     : segments {a..g}, bit 6 = a, 1 = lit
//   an[N-1:0]    : one-hot digit select, bit i = digit i
//   bcd          : last legal value per digit, digit i at [4i+3:4i]
//   digit_valid  : last latch of digit i was legal
//   digit_err    : last latch of digit i was illegal
//   update       : one-cycle pulse per latch
//   frame_done   : one-cycle pulse once every digit has latched
module seg7_to_bcd_scanner #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [6:0]              seg,
  input  logic [NUM_DIGITS-1:0]   an,
  output logic [4*NUM_DIGITS-1:0] bcd,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic [NUM_DIGITS-1:0]   digit_err,
  output logic                    update,
  output logic                    frame_done
);

  localparam int SW = NUM_DIGITS + 7;
  localparam logic [3:0] STABLE = 4'(STABLE_CYCLES);
  localparam logic [NUM_DIGITS-1:0] ONE = 1;

  logic [SW-1:0]         smp;
  logic [SW-1:0]         smp_in;
  logic [3:0]            cnt;
  logic [3:0]            cnt_nxt;
  logic                  latched;
  logic                  latched_nxt;
  logic [NUM_DIGITS-1:0] seen;
  logic [NUM_DIGITS-1:0] seen_or;
  logic [NUM_DIGITS-1:0] sel;
  logic                  same;
  logic                  onehot;
  logic                  do_latch;
  logic                  full;
  logic                  legal;
  logic [3:0]            val;

  assign smp_in = {an, seg};
  assign sel    = smp[SW-1:7];
  assign same   = (smp_in == smp);
  assign onehot = (sel != '0) && ((sel & (sel - ONE)) == '0);

  // Latch decisions use the registered sample, so a pattern change
  // arriving on the latching edge cannot cancel the latch.
  assign do_latch = (cnt == STABLE) && !latched && onehot;
  assign seen_or  = seen | sel;
  assign full     = &seen_or;

  always_comb begin
    legal = 1'b1;
    val   = 4'd0;
    case (smp[6:0])
      7'b1111110: val = 4'd0;
      7'b0110000: val = 4'd1;
      7'b1101101: val = 4'd2;
      7'b1111001: val = 4'd3;
      7'b0110011: val = 4'd4;
      7'b1011011: val = 4'd5;
      7'b1011111: val = 4'd6;
      7'b1110000: val = 4'd7;
      7'b1111111: val = 4'd8;
      7'b1111011: val = 4'd9;
      default:    legal = 1'b0;
    endcase
  end

  // A changed sample starts a new run and re-arms the latch.
  always_comb begin
    cnt_nxt     = 4'd1;
    latched_nxt = 1'b0;
    if (same) begin
      cnt_nxt     = (cnt == STABLE) ? cnt : cnt + 4'd1;
      latched_nxt = latched | do_latch;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      smp         <= '0;
      cnt         <= '0;
      latched     <= 1'b0;
      seen        <= '0;
      bcd         <= '0;
      digit_valid <= '0;
      digit_err   <= '0;
      update      <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      smp        <= smp_in;
      cnt        <= cnt_nxt;
      latched    <= latched_nxt;
      update     <= do_latch;
      frame_done <= do_latch && full;
      if (do_latch) begin
        seen <= full ? '0 : seen_or;
      end
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (do_latch && sel[i]) begin
          digit_valid[i] <= legal;
          digit_err[i]   <= !legal;
          if (legal) begin
            bcd[4*i +: 4] <= val;
          end
        end
      end
    end
  end

endmodule
